// File: rtl/dtm_jtag.sv
// JTAG debug transport module: oversampled TAP with IDCODE/DTMCS/DMI/BYPASS registers driving a DMI requester.
// Optional IDCODE register enabled by defining DTM_IDCODE_EN (otherwise opcode 0x01 and IR reset select BYPASS).
module dtm_jtag #(
    parameter logic [31:0] IDCODE = 32'h1000_0001,
    parameter int          ABITS  = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             jtag_tck,
    input  logic             jtag_tms,
    input  logic             jtag_tdi,
    output logic             jtag_tdo,
    output logic             dmi_valid,
    input  logic             dmi_ready,
    output logic             dmi_write,
    output logic [ABITS-1:0] dmi_addr,
    output logic [31:0]      dmi_wdata,
    input  logic [31:0]      dmi_rdata
);

    localparam int DR_W = ABITS + 34;

`ifdef DTM_IDCODE_EN
    localparam logic [4:0] IR_RESET = 5'h01;
`else
    localparam logic [4:0] IR_RESET = 5'h1F;
`endif

    typedef enum logic [3:0] {
        TAP_TLR, TAP_RTI, TAP_SEL_DR, TAP_CAP_DR, TAP_SHIFT_DR, TAP_EXIT1_DR,
        TAP_PAUSE_DR, TAP_EXIT2_DR, TAP_UPD_DR, TAP_SEL_IR, TAP_CAP_IR,
        TAP_SHIFT_IR, TAP_EXIT1_IR, TAP_PAUSE_IR, TAP_EXIT2_IR, TAP_UPD_IR
    } tap_state_e;

    typedef enum logic [1:0] {DR_BYPASS, DR_IDCODE, DR_DTMCS, DR_DMI} dr_sel_e;

    logic tck_s1_q, tck_s2_q, tck_s3_q;
    logic tms_s1_q, tms_s2_q;
    logic tdi_s1_q, tdi_s2_q;
    logic tck_rise, tck_fall;

    tap_state_e        tap_q, tap_d, tap_next;
    logic [4:0]        ir_q, ir_d;
    logic [4:0]        ir_shift_q, ir_shift_d;
    logic [DR_W-1:0]   dr_shift_q, dr_shift_d;
    logic [1:0]        dmistat_q, dmistat_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              tdo_q, tdo_d;
    logic              dmi_valid_q, dmi_valid_d;
    logic              dmi_write_q, dmi_write_d;
    logic [ABITS-1:0]  dmi_addr_q, dmi_addr_d;
    logic [31:0]       dmi_wdata_q, dmi_wdata_d;

    dr_sel_e           dr_sel;
    logic              xfer, busy;
    logic [31:0]       dtmcs_cap;
    logic [1:0]        upd_op;

    // Shift tdi into the MSB of whichever register is active; the rest moves one bit toward the LSB.
    function automatic logic [DR_W-1:0] shift_dr(input logic [DR_W-1:0] cur, input logic bit_in,
                                                 input dr_sel_e sel);
        logic [DR_W-1:0] r;
        r = cur >> 1;
        case (sel)
            DR_BYPASS: r[0] = bit_in;
            DR_DMI:    r[DR_W-1] = bit_in;
            default:   r[31] = bit_in;
        endcase
        return r;
    endfunction

    assign tck_rise = tck_s2_q & ~tck_s3_q;
    assign tck_fall = ~tck_s2_q & tck_s3_q;

    assign xfer = dmi_valid_q & dmi_ready;
    assign busy = dmi_valid_q & ~dmi_ready;

    assign dtmcs_cap = {17'b0, 3'd1, dmistat_q, 6'(ABITS), 4'd1};
    assign upd_op    = dr_shift_q[1:0];

    always_comb begin
        dr_sel = DR_BYPASS;
        case (ir_q)
`ifdef DTM_IDCODE_EN
            5'h01:   dr_sel = DR_IDCODE;
`endif
            5'h10:   dr_sel = DR_DTMCS;
            5'h11:   dr_sel = DR_DMI;
            default: dr_sel = DR_BYPASS;
        endcase
    end

    always_comb begin
        tap_next = tap_q;
        case (tap_q)
            TAP_TLR:      tap_next = tms_s2_q ? TAP_TLR      : TAP_RTI;
            TAP_RTI:      tap_next = tms_s2_q ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_DR:   tap_next = tms_s2_q ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:   tap_next = tms_s2_q ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR: tap_next = tms_s2_q ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_EXIT1_DR: tap_next = tms_s2_q ? TAP_UPD_DR   : TAP_PAUSE_DR;
            TAP_PAUSE_DR: tap_next = tms_s2_q ? TAP_EXIT2_DR : TAP_PAUSE_DR;
            TAP_EXIT2_DR: tap_next = tms_s2_q ? TAP_UPD_DR   : TAP_SHIFT_DR;
            TAP_UPD_DR:   tap_next = tms_s2_q ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_IR:   tap_next = tms_s2_q ? TAP_TLR      : TAP_CAP_IR;
            TAP_CAP_IR:   tap_next = tms_s2_q ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR: tap_next = tms_s2_q ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_EXIT1_IR: tap_next = tms_s2_q ? TAP_UPD_IR   : TAP_PAUSE_IR;
            TAP_PAUSE_IR: tap_next = tms_s2_q ? TAP_EXIT2_IR : TAP_PAUSE_IR;
            TAP_EXIT2_IR: tap_next = tms_s2_q ? TAP_UPD_IR   : TAP_SHIFT_IR;
            TAP_UPD_IR:   tap_next = tms_s2_q ? TAP_SEL_DR   : TAP_RTI;
            default:      tap_next = TAP_TLR;
        endcase
    end

    always_comb begin
        tap_d       = tap_q;
        ir_d        = ir_q;
        ir_shift_d  = ir_shift_q;
        dr_shift_d  = dr_shift_q;
        dmistat_d   = dmistat_q;
        rdata_d     = rdata_q;
        tdo_d       = tdo_q;
        dmi_valid_d = dmi_valid_q;
        dmi_write_d = dmi_write_q;
        dmi_addr_d  = dmi_addr_q;
        dmi_wdata_d = dmi_wdata_q;

        // Retire the transfer before any TAP action so a same-cycle capture/update sees it done.
        if (xfer) begin
            dmi_valid_d = 1'b0;
            if (!dmi_write_q) begin
                rdata_d = dmi_rdata;
            end
        end

        if (tck_rise) begin
            tap_d = tap_next;
            case (tap_q)
                TAP_TLR:      ir_d = IR_RESET;
                TAP_CAP_IR:   ir_shift_d = 5'b00001;
                TAP_SHIFT_IR: ir_shift_d = {tdi_s2_q, ir_shift_q[4:1]};
                TAP_UPD_IR:   ir_d = ir_shift_q;
                TAP_CAP_DR: begin
                    case (dr_sel)
                        DR_IDCODE: dr_shift_d = {{(DR_W-32){1'b0}}, IDCODE};
                        DR_DTMCS:  dr_shift_d = {{(DR_W-32){1'b0}}, dtmcs_cap};
                        DR_DMI: begin
                            dr_shift_d = {dmi_addr_q, rdata_d, (busy ? 2'd3 : dmistat_q)};
                            if (busy) begin
                                dmistat_d = 2'd3;
                            end
                        end
                        default:   dr_shift_d = '0;
                    endcase
                end
                TAP_SHIFT_DR: dr_shift_d = shift_dr(dr_shift_q, tdi_s2_q, dr_sel);
                TAP_UPD_DR: begin
                    if (dr_sel == DR_DTMCS) begin
                        if (dr_shift_q[16] || dr_shift_q[17]) begin
                            dmistat_d = 2'd0;
                        end
                    end else if (dr_sel == DR_DMI) begin
                        if (busy) begin
                            dmistat_d = 2'd3;
                        end else if (dmistat_q == 2'd0 && (upd_op == 2'd1 || upd_op == 2'd2)) begin
                            dmi_valid_d = 1'b1;
                            dmi_write_d = (upd_op == 2'd2);
                            dmi_addr_d  = dr_shift_q[DR_W-1 -: ABITS];
                            dmi_wdata_d = dr_shift_q[33:2];
                        end
                    end
                end
                default: ;
            endcase
        end

        if (tck_fall) begin
            if (tap_q == TAP_SHIFT_IR) begin
                tdo_d = ir_shift_q[0];
            end else if (tap_q == TAP_SHIFT_DR) begin
                tdo_d = dr_shift_q[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tck_s1_q    <= 1'b0;
            tck_s2_q    <= 1'b0;
            tck_s3_q    <= 1'b0;
            tms_s1_q    <= 1'b0;
            tms_s2_q    <= 1'b0;
            tdi_s1_q    <= 1'b0;
            tdi_s2_q    <= 1'b0;
            tap_q       <= TAP_TLR;
            ir_q        <= IR_RESET;
            dmistat_q   <= 2'd0;
            rdata_q     <= 32'd0;
            tdo_q       <= 1'b0;
            dmi_valid_q <= 1'b0;
            dmi_write_q <= 1'b0;
            dmi_addr_q  <= '0;
            dmi_wdata_q <= 32'd0;
        end else begin
            tck_s1_q    <= jtag_tck;
            tck_s2_q    <= tck_s1_q;
            tck_s3_q    <= tck_s2_q;
            tms_s1_q    <= jtag_tms;
            tms_s2_q    <= tms_s1_q;
            tdi_s1_q    <= jtag_tdi;
            tdi_s2_q    <= tdi_s1_q;
            tap_q       <= tap_d;
            ir_q        <= ir_d;
            dmistat_q   <= dmistat_d;
            rdata_q     <= rdata_d;
            tdo_q       <= tdo_d;
            dmi_valid_q <= dmi_valid_d;
            dmi_write_q <= dmi_write_d;
            dmi_addr_q  <= dmi_addr_d;
            dmi_wdata_q <= dmi_wdata_d;
        end
    end

    // Shift registers are always loaded by a capture before use, so they need no reset.
    always_ff @(posedge clk) begin
        ir_shift_q <= ir_shift_d;
        dr_shift_q <= dr_shift_d;
    end

    assign jtag_tdo  = tdo_q;
    assign dmi_valid = dmi_valid_q;
    assign dmi_write = dmi_write_q;
    assign dmi_addr  = dmi_addr_q;
    assign dmi_wdata = dmi_wdata_q;

endmodule

// File: tb/tb_dtm_jtag.sv
// Directed bench for dtm_jtag: bit-banged JTAG scans against hand-computed register images and DMI handshakes.
module tb_dtm_jtag;

    logic        clk = 1'b0;
    logic        reset;
    logic        jtag_tck, jtag_tms, jtag_tdi;
    logic        jtag_tdo;
    logic        dmi_valid, dmi_ready, dmi_write;
    logic [6:0]  dmi_addr;
    logic [31:0] dmi_wdata, dmi_rdata;

    int checks = 0;
    int failures = 0;

    dtm_jtag #(.IDCODE(32'h1000_0001), .ABITS(7)) dut (
        .clk(clk), .reset(reset),
        .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi), .jtag_tdo(jtag_tdo),
        .dmi_valid(dmi_valid), .dmi_ready(dmi_ready), .dmi_write(dmi_write),
        .dmi_addr(dmi_addr), .dmi_wdata(dmi_wdata), .dmi_rdata(dmi_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [40:0] dmi_word(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
        return {a, d, op};
    endfunction

    // One TCK period: six clk low (TDO sampled at the end), six clk high.
    task automatic jtag_clk(input logic t_ms, input logic t_di, output logic t_do);
        jtag_tms = t_ms;
        jtag_tdi = t_di;
        repeat (6) @(negedge clk);
        t_do = jtag_tdo;
        jtag_tck = 1'b1;
        repeat (6) @(negedge clk);
        jtag_tck = 1'b0;
    endtask

    task automatic tap_reset();
        logic d;
        for (int i = 0; i < 5; i++) jtag_clk(1'b1, 1'b0, d);
        jtag_clk(1'b0, 1'b0, d);
    endtask

    task automatic scan_ir(input logic [4:0] v, output logic [4:0] o);
        logic d;
        jtag_clk(1'b1, 1'b0, d);
        jtag_clk(1'b1, 1'b0, d);
        jtag_clk(1'b0, 1'b0, d);
        jtag_clk(1'b0, 1'b0, d);
        for (int i = 0; i < 5; i++) begin
            jtag_clk(i == 4, v[i], d);
            o[i] = d;
        end
        jtag_clk(1'b1, 1'b0, d);
        jtag_clk(1'b0, 1'b0, d);
    endtask

    task automatic scan_dr(input logic [40:0] din, input int n, output logic [40:0] dout);
        logic d;
        dout = '0;
        jtag_clk(1'b1, 1'b0, d);
        jtag_clk(1'b0, 1'b0, d);
        jtag_clk(1'b0, 1'b0, d);
        for (int i = 0; i < n; i++) begin
            jtag_clk(i == n - 1, din[i], d);
            dout[i] = d;
        end
        jtag_clk(1'b1, 1'b0, d);
        jtag_clk(1'b0, 1'b0, d);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checks += 5;
        if (jtag_tdo !== 1'b0) begin failures++; $display("FAIL rst_tdo got=%0b exp=0", jtag_tdo); end
        if (dmi_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", dmi_valid); end
        if (dmi_write !== 1'b0) begin failures++; $display("FAIL rst_write got=%0b exp=0", dmi_write); end
        if (dmi_addr !== 7'h00) begin failures++; $display("FAIL rst_addr got=%h exp=00", dmi_addr); end
        if (dmi_wdata !== 32'h0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", dmi_wdata); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_idcode(input string tag);
        logic [40:0] din, dout, exp;
        tap_reset();
`ifdef DTM_IDCODE_EN
        din = '0;
        exp = {9'b0, 32'h1000_0001};
`else
        din = {9'b0, 32'hA5C3_3C5A};
        exp = {9'b0, din[30:0], 1'b0};
`endif
        scan_dr(din, 32, dout);
        checks++;
        if (dout[31:0] !== exp[31:0]) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, dout[31:0], exp[31:0]);
        end
    endtask

    task automatic test_dtmcs();
        logic [4:0]  o;
        logic [40:0] dout;
        scan_ir(5'h10, o);
        checks++;
        if (o !== 5'b00001) begin failures++; $display("FAIL ir_capture got=%b exp=00001", o); end
        scan_dr('0, 32, dout);
        checks++;
        if (dout[31:0] !== 32'h0000_1071) begin failures++; $display("FAIL dtmcs got=%h exp=00001071", dout[31:0]); end
    endtask

    task automatic test_dmi_write();
        logic [4:0]  o;
        logic [40:0] dout;
        scan_ir(5'h11, o);
        scan_dr(dmi_word(7'h04, 32'hDEAD_BEEF, 2'd2), 41, dout);
        checks += 5;
        if (dout !== dmi_word(7'h00, 32'h0, 2'd0)) begin failures++; $display("FAIL wr_first_cap got=%h exp=0", dout); end
        if (dmi_valid !== 1'b1) begin failures++; $display("FAIL wr_valid got=%0b exp=1", dmi_valid); end
        if (dmi_write !== 1'b1) begin failures++; $display("FAIL wr_write got=%0b exp=1", dmi_write); end
        if (dmi_addr !== 7'h04) begin failures++; $display("FAIL wr_addr got=%h exp=04", dmi_addr); end
        if (dmi_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_wdata got=%h exp=deadbeef", dmi_wdata); end
        repeat (10) @(negedge clk);
        dmi_ready = 1'b1;
        checks += 4;
        if (dmi_valid !== 1'b1) begin failures++; $display("FAIL wr_hold_valid got=%0b exp=1", dmi_valid); end
        if (dmi_write !== 1'b1) begin failures++; $display("FAIL wr_hold_write got=%0b exp=1", dmi_write); end
        if (dmi_addr !== 7'h04) begin failures++; $display("FAIL wr_hold_addr got=%h exp=04", dmi_addr); end
        if (dmi_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_hold_wdata got=%h exp=deadbeef", dmi_wdata); end
        @(negedge clk);
        dmi_ready = 1'b0;
        checks++;
        if (dmi_valid !== 1'b0) begin failures++; $display("FAIL wr_valid_drop got=%0b exp=0", dmi_valid); end
        scan_dr(dmi_word(7'h00, 32'h0, 2'd0), 41, dout);
        checks++;
        if (dout !== dmi_word(7'h04, 32'h0, 2'd0)) begin failures++; $display("FAIL wr_next_cap got=%h exp=%h", dout, dmi_word(7'h04, 32'h0, 2'd0)); end
    endtask

    task automatic test_dmi_read();
        logic [40:0] dout;
        scan_dr(dmi_word(7'h11, 32'h0, 2'd1), 41, dout);
        checks += 2;
        if (dmi_valid !== 1'b1 || dmi_write !== 1'b0) begin
            failures++; $display("FAIL rd_req valid=%0b write=%0b exp valid=1 write=0", dmi_valid, dmi_write);
        end
        if (dmi_addr !== 7'h11) begin failures++; $display("FAIL rd_addr got=%h exp=11", dmi_addr); end
        repeat (3) @(negedge clk);
        dmi_rdata = 32'h0000_0003;
        dmi_ready = 1'b1;
        @(negedge clk);
        dmi_ready = 1'b0;
        dmi_rdata = 32'hFFFF_FFFF;
        checks++;
        if (dmi_valid !== 1'b0) begin failures++; $display("FAIL rd_valid_drop got=%0b exp=0", dmi_valid); end
        scan_dr(dmi_word(7'h00, 32'h0, 2'd0), 41, dout);
        checks++;
        if (dout !== dmi_word(7'h11, 32'h3, 2'd0)) begin failures++; $display("FAIL rd_cap got=%h exp=%h", dout, dmi_word(7'h11, 32'h3, 2'd0)); end
    endtask

    task automatic test_busy();
        logic [4:0]  o;
        logic [40:0] dout;
        scan_dr(dmi_word(7'h05, 32'h0000_1234, 2'd2), 41, dout);
        checks++;
        if (dout !== dmi_word(7'h11, 32'h3, 2'd0)) begin failures++; $display("FAIL busy_first_cap got=%h exp=%h", dout, dmi_word(7'h11, 32'h3, 2'd0)); end
        scan_dr(dmi_word(7'h06, 32'h0000_9999, 2'd2), 41, dout);
        checks += 3;
        if (dout !== dmi_word(7'h05, 32'h3, 2'd3)) begin failures++; $display("FAIL busy_cap got=%h exp=%h", dout, dmi_word(7'h05, 32'h3, 2'd3)); end
        if (dmi_valid !== 1'b1 || dmi_addr !== 7'h05) begin
            failures++; $display("FAIL busy_hold valid=%0b addr=%h exp valid=1 addr=05", dmi_valid, dmi_addr);
        end
        if (dmi_wdata !== 32'h0000_1234) begin failures++; $display("FAIL busy_wdata got=%h exp=00001234", dmi_wdata); end
        scan_ir(5'h10, o);
        scan_dr('0, 32, dout);
        checks++;
        if (dout[31:0] !== 32'h0000_1C71) begin failures++; $display("FAIL busy_dtmcs got=%h exp=00001c71", dout[31:0]); end
        @(negedge clk);
        dmi_ready = 1'b1;
        @(negedge clk);
        dmi_ready = 1'b0;
        scan_ir(5'h11, o);
        scan_dr(dmi_word(7'h06, 32'h0000_9999, 2'd2), 41, dout);
        checks += 2;
        if (dout !== dmi_word(7'h05, 32'h3, 2'd3)) begin failures++; $display("FAIL sticky_cap got=%h exp=%h", dout, dmi_word(7'h05, 32'h3, 2'd3)); end
        if (dmi_valid !== 1'b0) begin failures++; $display("FAIL sticky_no_req got=%0b exp=0", dmi_valid); end
        scan_ir(5'h10, o);
        scan_dr(41'h1_0000, 32, dout);
        checks++;
        if (dout[31:0] !== 32'h0000_1C71) begin failures++; $display("FAIL clr_dtmcs_before got=%h exp=00001c71", dout[31:0]); end
        scan_dr('0, 32, dout);
        checks++;
        if (dout[31:0] !== 32'h0000_1071) begin failures++; $display("FAIL clr_dtmcs_after got=%h exp=00001071", dout[31:0]); end
        scan_ir(5'h11, o);
        scan_dr(dmi_word(7'h07, 32'h0000_0055, 2'd2), 41, dout);
        checks += 2;
        if (dout !== dmi_word(7'h05, 32'h3, 2'd0)) begin failures++; $display("FAIL clr_cap got=%h exp=%h", dout, dmi_word(7'h05, 32'h3, 2'd0)); end
        if (dmi_valid !== 1'b1 || dmi_addr !== 7'h07 || dmi_wdata !== 32'h55) begin
            failures++; $display("FAIL clr_req valid=%0b addr=%h wdata=%h exp 1/07/00000055", dmi_valid, dmi_addr, dmi_wdata);
        end
        @(negedge clk);
        dmi_ready = 1'b1;
        @(negedge clk);
        dmi_ready = 1'b0;
    endtask

    task automatic test_reset_mid_request();
        logic [40:0] dout;
        scan_dr(dmi_word(7'h09, 32'hCAFE_F00D, 2'd2), 41, dout);
        checks++;
        if (dmi_valid !== 1'b1) begin failures++; $display("FAIL mid_req_valid got=%0b exp=1", dmi_valid); end
        reset = 1'b1;
        @(negedge clk);
        checks += 5;
        if (dmi_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%0b exp=0", dmi_valid); end
        if (dmi_write !== 1'b0) begin failures++; $display("FAIL mid_write got=%0b exp=0", dmi_write); end
        if (dmi_addr !== 7'h00) begin failures++; $display("FAIL mid_addr got=%h exp=00", dmi_addr); end
        if (dmi_wdata !== 32'h0) begin failures++; $display("FAIL mid_wdata got=%h exp=0", dmi_wdata); end
        if (jtag_tdo !== 1'b0) begin failures++; $display("FAIL mid_tdo got=%0b exp=0", jtag_tdo); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        jtag_tck  = 1'b0;
        jtag_tms  = 1'b1;
        jtag_tdi  = 1'b0;
        dmi_ready = 1'b0;
        dmi_rdata = 32'h0;
        test_reset();
        test_idcode("idcode_scan");
        test_dtmcs();
        test_dmi_write();
        test_dmi_read();
        test_busy();
        test_reset_mid_request();
        test_idcode("idcode_after_reset");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
